// File: rtl/z80_busarb.sv
// Round-robin bus-request arbiter for the Z80 external bus (nBUSRQ/nBUSACK).
// Define Z80_BUSARB_FAIRGAP_EN to hold nBUSRQ high for GAP_CYCLES between tenures.
module z80_busarb #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 64,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   nBUSRQ,
  input  logic                   nBUSACK,
  output logic                   busy,
  output logic                   timeout
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANT, S_RELEASE, S_GAP
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [HW-1:0]   hold_cnt;
  logic [PW-1:0]   win;
  logic [PW-1:0]   lo_w;
  logic [PW-1:0]   hi_w;
  logic            hi_v;
  logic [PW-1:0]   nxt_ptr;
  logic            owner_req;
  logic            hold_end;

`ifdef Z80_BUSARB_FAIRGAP_EN
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  logic [GW-1:0] gap_cnt;
`endif

  // Descending scan: last hit is the lowest index, so hi_w is
  // the first requester at/after rr_ptr and lo_w the wrap fallback.
  always_comb begin
    lo_w = '0;
    hi_w = '0;
    hi_v = 1'b0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_w = PW'(j);
        if (j >= int'(rr_ptr)) begin
          hi_w = PW'(j);
          hi_v = 1'b1;
        end
      end
    end
    win = hi_v ? hi_w : lo_w;
  end

  assign nxt_ptr   = (win == PW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
  assign owner_req = |(req & grant);
  assign hold_end  = (MAX_HOLD != 0) && (hold_cnt == HW'(HOLD_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      nBUSRQ   <= 1'b1;
      busy     <= 1'b0;
      timeout  <= 1'b0;
`ifdef Z80_BUSARB_FAIRGAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            state  <= S_REQ;
            nBUSRQ <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_REQ: begin
          if (!nBUSACK) begin
            if (|req) begin
              grant    <= NUM_MASTERS'(1) << win;
              rr_ptr   <= nxt_ptr;
              hold_cnt <= '0;
              state    <= S_GRANT;
            end else begin
              nBUSRQ <= 1'b1;
              state  <= S_RELEASE;
            end
          end
        end
        S_GRANT: begin
          if (hold_cnt != {HW{1'b1}}) hold_cnt <= hold_cnt + 1'b1;
          if (!owner_req || hold_end) begin
            grant   <= '0;
            nBUSRQ  <= 1'b1;
            timeout <= owner_req;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (nBUSACK) begin
`ifdef Z80_BUSARB_FAIRGAP_EN
            gap_cnt <= '0;
            state   <= S_GAP;
`else
            busy    <= 1'b0;
            state   <= S_IDLE;
`endif
          end
        end
        default: begin
`ifdef Z80_BUSARB_FAIRGAP_EN
          if (gap_cnt >= GW'(GAP_LAST)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
`else
          busy  <= 1'b0;
          state <= S_IDLE;
`endif
        end
      endcase
    end
  end

endmodule
